masking_encoder_d3: RTL

- Converts an unmasked W-bit value into four Boolean shares (d=3) for the masked gadgets in the combined-random-model designs (e.g. the HPC2 AND gate). It is the entry point of a masked datapath.
- Masking uses 3W fresh random bits. Optionally, REFRESH extra ring-refresh rounds follow, each consuming 3W further random bits.
- Valid/ready handshakes sit on the data input, the randomness input and the share output.

---
 rtl/masking_encoder_d3.sv | 108 ++++++++++
 1 files changed

// File: rtl/masking_encoder_d3.sv
// Boolean masking encoder: splits a W-bit word into four shares (d=3), then
// applies REFRESH ring-refresh rounds with fresh randomness before handing off.
module masking_encoder_d3 #(
  parameter int unsigned W       = 1,
  parameter int unsigned REFRESH = 1
) (
  input  logic           clock_0,
  input  logic           reset_0,
  input  logic           io_in_valid,
  output logic           io_in_ready,
  input  logic [W-1:0]   io_in_data,
  input  logic [3*W-1:0] p_rand,
  input  logic           p_rand_valid,
  output logic           p_rand_ready,
  output logic [W-1:0]   io_o0_s0,
  output logic [W-1:0]   io_o0_s1,
  output logic [W-1:0]   io_o0_s2,
  output logic [W-1:0]   io_o0_s3,
  output logic           io_out_valid,
  input  logic           io_out_ready,
  output logic           io_busy
);

  typedef enum logic [1:0] {ST_IDLE, ST_MASK, ST_REFRESH, ST_DONE} state_t;

  localparam logic [2:0] LAST_ROUND = (REFRESH > 0) ? 3'(REFRESH - 1) : 3'd0;

  state_t       state, state_nxt;
  logic [W-1:0] data_q;
  logic [W-1:0] s0_q, s1_q, s2_q, s3_q;
  logic [2:0]   cnt_q;
  logic [W-1:0] r0, r1, r2;
  logic         in_xfer, rand_xfer, out_xfer;

  assign r0 = p_rand[W-1:0];
  assign r1 = p_rand[2*W-1:W];
  assign r2 = p_rand[3*W-1:2*W];

  // Handshake outputs come from the state decode only, never from inputs.
  assign io_in_ready  = (state == ST_IDLE);
  assign p_rand_ready = (state == ST_MASK) || (state == ST_REFRESH);
  assign io_out_valid = (state == ST_DONE);
  assign io_busy      = (state != ST_IDLE);

  assign in_xfer   = io_in_valid & io_in_ready;
  assign rand_xfer = p_rand_valid & p_rand_ready;
  assign out_xfer  = io_out_ready & io_out_valid;

  assign io_o0_s0 = s0_q;
  assign io_o0_s1 = s1_q;
  assign io_o0_s2 = s2_q;
  assign io_o0_s3 = s3_q;

  always_ff @(posedge clock_0 or posedge reset_0) begin
    if (reset_0) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (in_xfer) state_nxt = ST_MASK;
      ST_MASK:    if (rand_xfer) state_nxt = (REFRESH > 0) ? ST_REFRESH : ST_DONE;
      ST_REFRESH: if (rand_xfer && (cnt_q == LAST_ROUND)) state_nxt = ST_DONE;
      ST_DONE:    if (out_xfer) state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // s0 is written only with the already-masked value; data is zeroised once used.
  always_ff @(posedge clock_0 or posedge reset_0) begin
    if (reset_0) begin
      data_q <= '0;
      cnt_q  <= '0;
      s0_q   <= '0;
      s1_q   <= '0;
      s2_q   <= '0;
      s3_q   <= '0;
    end else begin
      case (state)
        ST_IDLE: if (in_xfer) data_q <= io_in_data;
        ST_MASK: if (rand_xfer) begin
          s0_q   <= data_q ^ r0 ^ r1 ^ r2;
          s1_q   <= r0;
          s2_q   <= r1;
          s3_q   <= r2;
          data_q <= '0;
          cnt_q  <= '0;
        end
        ST_REFRESH: if (rand_xfer) begin
          s0_q  <= s0_q ^ r0;
          s1_q  <= s1_q ^ r0 ^ r1;
          s2_q  <= s2_q ^ r1 ^ r2;
          s3_q  <= s3_q ^ r2;
          cnt_q <= cnt_q + 3'd1;
        end
        ST_DONE: if (out_xfer) begin
          s0_q <= '0;
          s1_q <= '0;
          s2_q <= '0;
          s3_q <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule
